// File: rtl/simple_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : simple_rr_arbiter_if
// Brief    : Shared "simple" channel; the arbiter drives the dir1 side.
// Revision : 1.0 - initial release
// ============================================================================
interface simple_rr_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] simple1;
  logic             simple1_valid;
  logic [WIDTH-1:0] simple2;
  logic             simple2_valid;

  modport master (
    output simple1,
    output simple1_valid,
    input  simple2,
    input  simple2_valid
  );

  modport slave (
    input  simple1,
    input  simple1_valid,
    output simple2,
    output simple2_valid
  );
endinterface
`default_nettype wire

// File: rtl/simple_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : simple_rr_arbiter
// Brief    : Round-robin arbiter sharing one simple channel among NREQ
//            requesters. Optional WAIT timeout: define SIMPLE_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module simple_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  wire                    clk,
  input  wire                    rst,
  input  wire  [NREQ-1:0]        req_valid,
  input  wire  [NREQ*WIDTH-1:0]  req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  simple_rr_arbiter_if.master    chan
);

  localparam int c_iw = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("simple_rr_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("simple_rr_arbiter: TIMEOUT must be in 2..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NREQ-1:0]   r_grant;
  logic [c_iw-1:0]   r_owner;
  logic [c_iw-1:0]   r_last;
  logic [WIDTH-1:0]  r_simple1;
  logic [WIDTH-1:0]  r_rsp_data;

  logic [NREQ-1:0]   w_mask;
  logic [NREQ-1:0]   w_hi;
  logic [NREQ-1:0]   w_pool;
  logic [NREQ-1:0]   w_oh;
  logic [c_iw-1:0]   w_win;
  logic [WIDTH-1:0]  w_sel;
  logic              w_found;
  logic              w_accept;
  logic              w_capture;

`ifdef SIMPLE_ARB_TIMEOUT_EN
  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);
  logic [7:0]        r_cnt;
  logic              r_rsp_err;
  logic              w_expire;
`endif

  // Requests above the last owner take precedence; otherwise wrap to the lowest index.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_mask[i] = (c_iw'(i) > r_last);
    end
    w_hi    = req_valid & w_mask;
    w_pool  = (|w_hi) ? w_hi : req_valid;
    w_found = |req_valid;
    w_win   = '0;
    w_oh    = '0;
    w_sel   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_pool[i]) begin
        w_win    = c_iw'(i);
        w_oh     = '0;
        w_oh[i]  = 1'b1;
        w_sel    = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
`ifdef SIMPLE_ARB_TIMEOUT_EN
    w_expire    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (chan.simple2_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
`ifdef SIMPLE_ARB_TIMEOUT_EN
        else if (r_cnt == c_tmo_last) begin
          w_expire    = 1'b1;
          w_state_nxt = S_RESP;
        end
`endif
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant    <= '0;
      r_owner    <= '0;
      r_last     <= c_iw'(NREQ - 1);
      r_simple1  <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_simple1 <= w_sel;
        r_grant   <= w_oh;
        r_owner   <= w_win;
      end
      if (w_capture) begin
        r_rsp_data <= chan.simple2;
      end
`ifdef SIMPLE_ARB_TIMEOUT_EN
      else if (w_expire) begin
        r_rsp_data <= '0;
      end
`endif
      if (r_state == S_RESP) begin
        r_last  <= r_owner;
        r_grant <= '0;
      end
    end
  end

`ifdef SIMPLE_ARB_TIMEOUT_EN
  // Counter is zero on the first WAIT cycle and counts elapsed WAIT cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_capture) begin
        r_rsp_err <= 1'b0;
      end else if (w_expire) begin
        r_rsp_err <= 1'b1;
      end
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  // Gated by reset so the accept strobe also drops while reset is held.
  assign req_ready          = {NREQ{w_accept & rst}} & w_oh;
  assign rsp_valid          = (r_state == S_RESP) ? r_grant : '0;
  assign rsp_data           = r_rsp_data;
  assign grant              = r_grant;
  assign busy               = (r_state != S_IDLE);
  assign chan.simple1       = r_simple1;
  assign chan.simple1_valid = (r_state == S_ISSUE);

endmodule
`default_nettype wire

// File: tb/tb_simple_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_rr_arbiter
// Brief    : Self-checking bench for simple_rr_arbiter against a transaction
//            level model; honours SIMPLE_ARB_TIMEOUT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simple_rr_arbiter;
  localparam int NREQ    = 4;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*WIDTH-1:0]  req_data;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [WIDTH-1:0]       rsp_data;
  logic                   rsp_err;
  logic [NREQ-1:0]        grant;
  logic                   busy;
  int                     cyc = 0;
  int                     n_checks = 0;
  int                     n_errors = 0;

  simple_rr_arbiter_if #(.WIDTH(WIDTH)) chan ();

  simple_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .grant     (grant),
    .busy      (busy),
    .chan      (chan)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // First requester found searching upward from last+1, modulo NREQ.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    int idx;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Transaction-level model: owner, age since accept, waiting time, response due.
  bit               m_active = 0;
  bit               m_resp   = 0;
  bit               m_rerr   = 0;
  int               m_owner  = 0;
  int               m_last   = NREQ - 1;
  int               m_age    = 0;
  int               m_wcnt   = 0;
  logic [WIDTH-1:0] m_s1     = '0;
  logic [WIDTH-1:0] m_rdata  = '0;

  task automatic model_advance();
    int w;
    if (!rst) begin
      m_active = 0; m_resp = 0; m_rerr = 0; m_last = NREQ - 1;
      m_age = 0; m_wcnt = 0; m_s1 = '0; m_rdata = '0;
    end else if (!m_active) begin
      w = rr_pick(req_valid, m_last);
      if (w >= 0) begin
        m_active = 1; m_owner = w; m_age = 1;
        m_s1 = req_data[w*WIDTH +: WIDTH];
      end
    end else if (m_resp) begin
      m_active = 0; m_resp = 0; m_last = m_owner;
    end else if (m_age == 1) begin
      m_age = 2; m_wcnt = 0;
    end else begin
      if (chan.simple2_valid) begin
        m_rdata = chan.simple2; m_rerr = 0; m_resp = 1;
      end
`ifdef SIMPLE_ARB_TIMEOUT_EN
      else if (m_wcnt == TIMEOUT - 1) begin
        m_rdata = '0; m_rerr = 1; m_resp = 1;
      end
`endif
      m_wcnt++;
    end
  endtask

  initial begin : p_compare
    int w;
    logic [NREQ-1:0]  e_ready, e_grant, e_rspv;
    logic             e_busy, e_s1v, e_err;
    logic [WIDTH-1:0] e_s1, e_rdata;
    forever begin
      @(negedge clk);
      e_ready = '0; e_grant = '0; e_rspv = '0; e_busy = 0; e_s1v = 0;
      e_err = 0; e_s1 = '0; e_rdata = '0;
      if (rst) begin
        if (!m_active) begin
          w = rr_pick(req_valid, m_last);
          if (w >= 0) e_ready = onehot(w);
        end else begin
          e_grant = onehot(m_owner);
          e_busy  = 1;
          e_s1v   = (m_age == 1);
          if (m_resp) e_rspv = onehot(m_owner);
        end
        e_s1 = m_s1; e_rdata = m_rdata; e_err = m_rerr;
      end
      chk("m_req_ready", req_ready, e_ready);
      chk("m_grant", grant, e_grant);
      chk("m_busy", busy, e_busy);
      chk("m_simple1_valid", chan.simple1_valid, e_s1v);
      chk("m_simple1", chan.simple1, e_s1);
      chk("m_rsp_valid", rsp_valid, e_rspv);
      chk("m_rsp_data", rsp_data, e_rdata);
      chk("m_rsp_err", rsp_err, e_err);
      model_advance();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
  endtask

  task automatic wait_rsp(input logic [NREQ-1:0] exp, input string name, output int at);
    int n;
    n = 0;
    @(negedge clk);
    while (rsp_valid == '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, rsp_valid, exp);
    chk({name, "_grant"}, grant, exp);
    at = cyc;
  endtask

  initial begin : p_stim
    int at, prev, w0;
    rst = 1'b0; req_valid = '0; req_data = '0;
    chan.simple2 = '0; chan.simple2_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    chk("reset_simple1", chan.simple1, 0);
    chk("reset_rsp_data", rsp_data, 0);
    tick(); rst = 1'b1;

    // Single request
    tick(); req_valid = 4'b0001; req_data[31:0] = 32'h55AA;
    @(negedge clk); chk("single_ready", req_ready, 4'b0001);
    tick(); req_valid = '0;
    @(negedge clk);
    chk("single_simple1", chan.simple1, 32'h55AA);
    chk("single_s1_valid", chan.simple1_valid, 1);
    tick(); chan.simple2 = 32'h1234; chan.simple2_valid = 1'b1;
    tick(); chan.simple2_valid = 1'b0;
    @(negedge clk);
    chk("single_rsp_valid", rsp_valid, 4'b0001);
    chk("single_rsp_data", rsp_data, 32'h1234);

    // Contention from a fresh reset: order 0,1,2,3 x4, 4 cycles apart
    do_reset();
    req_valid = '1; chan.simple2_valid = 1'b1; chan.simple2 = 32'hA5A5_0000;
    prev = -1;
    for (int t = 0; t < 16; t++) begin
      wait_rsp(onehot(t % 4), "contend_order", at);
      if (prev >= 0) chk("contend_gap", at - prev, 4);
      prev = at;
    end

    // Pointer skip
    tick(); req_valid = 4'b0010;
    wait_rsp(4'b0010, "skip_first", at);
    tick(); req_valid = 4'b0011;
    wait_rsp(4'b0001, "skip_zero", at);
    wait_rsp(4'b0010, "skip_one", at);

    // Reset while in WAIT
    tick(); req_valid = '0; chan.simple2_valid = 1'b0;
    tick(); req_valid = 4'b0100;
    tick(); req_valid = '0;
    tick();
    tick(); rst = 1'b0; req_valid = 4'b0101;
    @(negedge clk);
    chk("rstwait_busy", busy, 0);
    chk("rstwait_grant", grant, 0);
    chk("rstwait_rsp_valid", rsp_valid, 0);
    chk("rstwait_s1_valid", chan.simple1_valid, 0);
    chk("rstwait_simple1", chan.simple1, 0);
    chk("rstwait_rsp_data", rsp_data, 0);
    chk("rstwait_ready", req_ready, 0);
    tick();
    tick(); rst = 1'b1;
    @(negedge clk); chk("rstwait_prio", req_ready, 4'b0001);
    tick(); req_valid = '0; chan.simple2_valid = 1'b1;
    wait_rsp(4'b0001, "rstwait_rsp", at);

    // Stray responses in IDLE and ISSUE
    tick(); chan.simple2 = 32'hDEAD; chan.simple2_valid = 1'b1;
    @(negedge clk); chk("stray_idle_busy", busy, 0);
    tick(); chan.simple2_valid = 1'b0;
    @(negedge clk); chk("stray_idle_rdata", rsp_data, 32'hA5A5_0000);
    tick(); req_valid = 4'b1000;
    tick(); req_valid = '0; chan.simple2 = 32'hBEEF; chan.simple2_valid = 1'b1;
    tick(); chan.simple2_valid = 1'b0;
    @(negedge clk);
    chk("stray_issue_busy", busy, 1);
    chk("stray_issue_rspv", rsp_valid, 0);
    tick();
    @(negedge clk); chk("stray_issue_rdata", rsp_data, 32'hA5A5_0000);
    tick(); chan.simple2 = 32'h777; chan.simple2_valid = 1'b1;
    wait_rsp(4'b1000, "stray_final", at);
    chk("stray_final_rdata", rsp_data, 32'h777);
    tick(); chan.simple2_valid = 1'b0;

    // No response after issue
    tick(); req_valid = 4'b0001;
    tick(); req_valid = '0;
    tick();
    @(negedge clk); w0 = cyc;
`ifdef SIMPLE_ARB_TIMEOUT_EN
    wait_rsp(4'b0001, "timeout_rsp", at);
    chk("timeout_latency", at - w0, 16);
    chk("timeout_err", rsp_err, 1);
    chk("timeout_rdata", rsp_data, 0);
`else
    repeat (40) tick();
    @(negedge clk);
    chk("unbounded_busy", busy, 1);
    chk("unbounded_rspv", rsp_valid, 0);
    do_reset();
`endif

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(0, 599) == 0) rst = 1'b0;
      else rst = 1'b1;
      req_valid = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = $urandom;
      chan.simple2       = $urandom;
      chan.simple2_valid = ($urandom_range(0, 3) == 0);
    end
    tick(); rst = 1'b1; req_valid = '0; chan.simple2_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/simple_rr_arbiter.md
Name: simple_rr_arbiter

Overview:
- Round-robin arbiter that shares one "simple" interface channel between NREQ requesters.
- Drives the dir1-side signals of the channel: simple1 is the outbound data, and simple2 is the returned data.
- Sequences each transaction as accept, issue, wait for response, then return the response to the owning requester.
- Sits between requester submodules and a single simple interface instance. This replaces the static single-driver connection of simple1.

Parameters:
- NREQ, 4: number of requesters. Legal range 2..8.
- WIDTH, 32: data width of simple1/simple2. Must match the interface WIDTH.
- TIMEOUT, 16: number of WAIT cycles before abort. Used only when SIMPLE_ARB_TIMEOUT_EN is defined. Legal range 2..255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request; held high until accepted.
- req_data  in  NREQ*WIDTH  packed request data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot accept pulse, combinational in IDLE.
- rsp_valid  out  NREQ  one-hot, one-cycle response strobe to the owner.
- rsp_data  out  WIDTH  registered response data.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- grant  out  NREQ  registered one-hot current owner; zero when idle.
- busy  out  1  high in every state except IDLE.
- simple1  out  WIDTH  registered outbound data to the channel.
- simple1_valid  out  1  one-cycle issue strobe.
- simple2  in  WIDTH  response data from the channel.
- simple2_valid  in  1  response strobe from the channel.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - grant, busy, req_ready, rsp_valid, rsp_err, simple1_valid, simple1 and rsp_data all go to 0.
  - Round-robin pointer last goes to NREQ-1, so requester 0 wins first.
  - The wait counter goes to 0.
- Reset mid-transaction aborts immediately: no rsp_valid is ever produced for the aborted owner, and that requester must re-request.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Winner w is the first i with req_valid[i] set, searching from last+1 upward modulo NREQ.
  - If a winner exists, req_ready[w]=1 this cycle. On the same edge: req_data slice w is captured into simple1, grant is set to onehot(w), and the state moves to ISSUE.
  - If no request is present, the arbiter stays in IDLE and all outputs hold.
- ISSUE: simple1_valid=1 for exactly one cycle, then move to WAIT. Any simple2_valid in this cycle is ignored.
- WAIT:
  - On simple2_valid, capture simple2 into rsp_data, set rsp_err=0, and move to RESP.
  - Otherwise stay in WAIT.
- RESP:
  - rsp_valid = grant for one cycle.
  - On the exit edge: last <= w, grant <= 0, and the state moves to IDLE.
  - There is no response backpressure.
- simple2_valid is ignored outside WAIT.
- simple1 holds its last issued value until the next accept.
- rsp_data holds its value until the next capture.
- Latency:
  - Accept to issue strobe: 1 cycle.
  - Minimum accept-to-rsp_valid: 3 cycles (simple2_valid in the first WAIT cycle).
  - Minimum back-to-back period: 4 cycles per transaction.
- A requester that drops req_valid before being accepted loses its slot with no side effects.
- req_valid is not sampled while busy.
- Fairness: with all requesters continuously asserting, the grant order is 0,1,...,NREQ-1,0.

Optional Feature:
- Macro: SIMPLE_ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit counter clears on entry to WAIT and increments every WAIT cycle.
  - If the count reaches TIMEOUT-1 without simple2_valid, the state moves to RESP with rsp_data=0 and rsp_err=1.
  - If simple2_valid coincides with expiry, the response wins and rsp_err=0.
- When undefined:
  - WAIT is unbounded.
  - rsp_err is tied to 0.
  - The counter logic is absent.

Test Plan:
- Single request: req_valid=4'b0001, data0=32'h55AA, simple2=32'h1234 on the first WAIT cycle.
  - req_ready=0001 at cycle 0.
  - simple1=55AA with simple1_valid at cycle 1.
  - rsp_valid=0001 with rsp_data=1234 at cycle 3.
- Contention: req_valid=4'b1111 held for 16 transactions, with simple2_valid answering immediately.
  - Grant order is 0,1,2,3 repeated 4 times.
  - rsp_valid pulses are spaced 4 cycles apart.
- Pointer skip: after a grant to 1, assert req_valid=4'b0011.
  - 0 wins next (search order 2,3,0).
  - 1 wins the transaction after that.
- Reset in WAIT: assert rst=0 for 2 cycles during WAIT.
  - All outputs are 0 immediately.
  - No rsp_valid appears.
  - After release, requester 0 has priority again.
- Stray response: pulse simple2_valid in the IDLE and ISSUE states.
  - No state change occurs and rsp_data is unchanged.
- Timeout (macro defined, TIMEOUT=16): no simple2_valid after issue.
  - rsp_valid appears 16 cycles after entering WAIT, with rsp_err=1 and rsp_data=0.
  - With the macro undefined, busy stays high indefinitely.
